irq_ctrl: RTL and testbench

Memory-mapped interrupt controller between the timer/external interrupt sources and the CPU's external interrupt input. It latches, masks and prioritises up to 8 sources and raises a single request line. It runs a claim / end-of-interrupt (EOI) handshake so one handler runs at a time. It sits behind the bridge as a third peripheral, next to TC1 and TC2, with its own 4-word address window.

---
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_ctrl.sv | 75 +++++++
 tb/tb_irq_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: bridge-side register bus for the interrupt controller window.
interface irq_ctrl_if;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output sel, addr, we, re, wdata, input rdata);
  modport slave  (input sel, addr, we, re, wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: latches, masks and prioritises N_SRC interrupts with claim/EOI handshake.
// Optional macro IRQ_CTRL_NEST_EN enables preemption by higher-priority sources.
module irq_ctrl #(
  parameter int N_SRC = 3
) (
  input  logic             clk,
  input  logic             reset,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq_out,
  output logic [2:0]       vec_id
);
  logic [N_SRC-1:0] r_s1, r_s2, r_s3, r_pend, r_mask, r_trig, r_inserv;
  logic [N_SRC-1:0] w_elig, w_rise, w_w1c, w_claim_oh, w_eoi_oh, w_pend_n;
  logic             w_valid, w_take, w_claim, w_eoi, w_wr;
  logic [2:0]       w_vec;
  logic             w_unused;
  assign w_unused = ^bus.wdata;
  assign w_elig   = r_pend & r_mask & ~r_inserv;
  assign w_valid  = |w_elig;
  assign w_rise   = r_s2 & ~r_s3;
  assign w_wr     = bus.sel & bus.we;
  assign w_w1c    = (w_wr && bus.addr == 2'd0) ? bus.wdata[N_SRC-1:0] : '0;
  assign w_eoi    = w_wr && bus.addr == 2'd3;
  assign w_claim  = bus.sel && bus.re && bus.addr == 2'd3 && w_take;
  assign vec_id   = w_vec;
  always_comb begin
    w_vec = '0;
    for (int i = N_SRC-1; i >= 0; i--) if (w_elig[i]) w_vec = 3'(i);
  end
  always_comb begin
    w_claim_oh = '0;
    w_eoi_oh   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_claim_oh[i] = w_claim && w_vec == 3'(i);
      w_eoi_oh[i]   = w_eoi && bus.wdata[2:0] == 3'(i);
    end
  end
`ifdef IRQ_CTRL_NEST_EN
  logic [2:0] w_ins_lo;
  always_comb begin
    w_ins_lo = '0;
    for (int i = N_SRC-1; i >= 0; i--) if (r_inserv[i]) w_ins_lo = 3'(i);
  end
  assign irq_out = w_valid && (r_inserv == '0 || w_vec < w_ins_lo);
  assign w_take  = w_valid;
`else
  assign irq_out = w_valid && r_inserv == '0;
  // claims only land while the request is raised, so a single handler is ever in service
  assign w_take  = irq_out;
`endif
  // edge sources hold until cleared; a new edge beats a same-cycle clear
  assign w_pend_n = (r_trig & ((r_pend & ~w_w1c & ~w_claim_oh) | w_rise)) | (~r_trig & r_s2);
  assign bus.rdata = bus.addr == 2'd0 ? 32'(r_pend) :
                     bus.addr == 2'd1 ? 32'(r_mask) :
                     bus.addr == 2'd2 ? 32'(r_trig) : {w_valid, 28'b0, w_vec};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_s3     <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_trig   <= '0;
      r_inserv <= '0;
    end else begin
      r_s1     <= irq_src;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_pend   <= w_pend_n;
      r_inserv <= (r_inserv & ~w_eoi_oh) | w_claim_oh;
      if (w_wr && bus.addr == 2'd1) r_mask <= bus.wdata[N_SRC-1:0];
      if (w_wr && bus.addr == 2'd2) r_trig <= bus.wdata[N_SRC-1:0];
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and randomized checks of irq_ctrl against a cycle-level reference model.
module tb_irq_ctrl;
  logic       clk = 0;
  logic       reset = 0;
  logic [2:0] irq_src = 0;
  logic       irq_out;
  logic [2:0] vec_id;
  irq_ctrl_if bus();
  irq_ctrl #(.N_SRC(3)) dut (.clk(clk), .reset(reset), .bus(bus), .irq_src(irq_src),
                             .irq_out(irq_out), .vec_id(vec_id));
  always #5 clk = ~clk;
  int n_pass = 0;
  int n_chk = 0;
  bit [2:0] m_pend, m_mask, m_trig, m_ins, cur;
  bit [2:0] hist [4];
  logic [31:0] last_rd;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lowest(bit [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit m_irq();
    bit [2:0] e;
    e = m_pend & m_mask & ~m_ins;
    if (e == 0) return 0;
`ifdef IRQ_CTRL_NEST_EN
    return m_ins == 0 || lowest(e) < lowest(m_ins);
`else
    return m_ins == 0;
`endif
  endfunction

  task automatic m_reset();
    m_pend = 0; m_mask = 0; m_trig = 0; m_ins = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
  endtask

  task automatic cycle(bit [2:0] src, bit sel, bit [1:0] addr, bit we, bit re, logic [31:0] wd);
    bit [2:0] e, lev, prev, w1c, np, ni;
    int v;
    bit valid, irq, claim, eoi;
    logic [31:0] exp_rd;
    cur = src;
    irq_src = src; bus.sel = sel; bus.addr = addr; bus.we = we; bus.re = re; bus.wdata = wd;
    #1;
    e = m_pend & m_mask & ~m_ins;
    valid = e != 0;
    v = lowest(e);
    irq = m_irq();
    exp_rd = addr == 0 ? 32'(m_pend) : addr == 1 ? 32'(m_mask) : addr == 2 ? 32'(m_trig)
           : {valid, 28'b0, 3'(v)};
    chk("irq_out", 32'(irq_out), 32'(irq));
    chk("vec_id", 32'(vec_id), 32'(v));
    chk("rdata", bus.rdata, exp_rd);
    last_rd = bus.rdata;
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = src;
    lev = hist[2];
    prev = hist[3];
`ifdef IRQ_CTRL_NEST_EN
    claim = sel && re && addr == 3 && valid;
`else
    claim = sel && re && addr == 3 && irq;
`endif
    eoi = sel && we && addr == 3;
    w1c = (sel && we && addr == 0) ? wd[2:0] : 3'b0;
    for (int i = 0; i < 3; i++)
      if (m_trig[i]) np[i] = (m_pend[i] && !w1c[i] && !(claim && v == i)) || (lev[i] && !prev[i]);
      else np[i] = lev[i];
    ni = m_ins;
    if (eoi && wd[2:0] < 3) ni[wd[2:0]] = 0;
    if (claim) ni[v] = 1;
    if (sel && we && addr == 1) m_mask = wd[2:0];
    if (sel && we && addr == 2) m_trig = wd[2:0];
    m_pend = np;
    m_ins = ni;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(cur, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.sel = 0; bus.addr = 0; bus.we = 0; bus.re = 0; bus.wdata = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1 chk("reset_rdata", bus.rdata, 0);
    end
    chk("reset_irq", 32'(irq_out), 0);
    reset = 1;
    @(negedge clk);
    // masked-on edge source 2: pulse, claim, EOI
    cycle(0, 1, 1, 1, 0, 7);
    cycle(0, 1, 2, 1, 0, 4);
    cycle(4, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    idle(1);
    chk("t1_irq", 32'(irq_out), 1);
    cycle(0, 1, 3, 0, 1, 0);
    chk("t1_claim", last_rd, 32'h80000002);
    cycle(0, 1, 0, 0, 0, 0);
    chk("t1_pend", last_rd, 0);
    cycle(0, 1, 3, 1, 0, 2);
    idle(1);
    chk("t1_eoi_irq", 32'(irq_out), 0);
    // level source 0 held high across EOI
    cycle(0, 1, 2, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    idle(2);
    cycle(1, 1, 3, 0, 1, 0);
    chk("t2_claim", last_rd, 32'h80000000);
    idle(1);
    chk("t2_irq_drop", 32'(irq_out), 0);
    cycle(1, 1, 3, 1, 0, 0);
    idle(1);
    chk("t2_reassert", 32'(irq_out), 1);
    cycle(0, 0, 0, 0, 0, 0);
    idle(2);
    chk("t2_pend_clear", 32'(bus.rdata), 0);
    // two edge sources pending, priority order
    cycle(0, 1, 2, 1, 0, 7);
    cycle(0, 1, 1, 1, 0, 7);
    cycle(6, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    idle(1);
    chk("t3_vec1", 32'(vec_id), 1);
    cycle(0, 1, 3, 0, 1, 0);
    cycle(0, 1, 3, 1, 0, 1);
    idle(1);
    chk("t3_vec2", 32'(vec_id), 2);
    cycle(0, 1, 3, 0, 1, 0);
    cycle(0, 1, 3, 1, 0, 2);
    // new edge races W1C, then an empty claim
    cycle(4, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 4);
    idle(1);
    chk("t4_pend_kept", 32'(bus.rdata), 4);
    cycle(0, 1, 0, 1, 0, 4);
    cycle(0, 1, 3, 0, 1, 0);
    chk("t4_empty_claim", last_rd, 0);
    // source 2 in service, then an edge on source 0
    cycle(4, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    idle(1);
    cycle(0, 1, 3, 0, 1, 0);
    chk("t5_claim2", last_rd, 32'h80000002);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    idle(1);
`ifdef IRQ_CTRL_NEST_EN
    chk("t5_preempt", 32'(irq_out), 1);
`else
    chk("t5_blocked", 32'(irq_out), 0);
`endif
    cycle(0, 1, 3, 0, 1, 0);
    chk("t5_claim0", last_rd, 32'h80000000);
    // reset mid-handler, observed before the next edge
    #2 reset = 0;
    bus.addr = 0;
    #1;
    chk("t6_irq", 32'(irq_out), 0);
    chk("t6_vec", 32'(vec_id), 0);
    chk("t6_pend", bus.rdata, 0);
    bus.addr = 1;
    #1 chk("t6_mask", bus.rdata, 0);
    m_reset();
    cur = 0;
    irq_src = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    for (int n = 0; n < 3000; n++) begin
      bit [2:0] s;
      bit [1:0] a;
      logic [31:0] wd;
      s = cur ^ (3'($urandom) & 3'($urandom) & 3'($urandom));
      a = 2'($urandom);
      wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      if (a == 1 && $urandom_range(0, 1) == 1) wd = 7;
      cycle(s, $urandom_range(0, 9) < 6, a, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, wd);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
